// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the E-stage multiply/divide unit:
//     md_op_e     operation codes carried on E_MDOp
//     md_state_e  sequencer states
//     MD_SEL_*    HI/LO read-select codes carried on E_MDDataOp
//     MD_CNT_W    latency counter width (covers latencies up to 255)
//     md_is_arith true for ops that occupy the unit for a latency window
//   Optional feature macro: MDU_MADD_EN (MADD/MADDU become arithmetic ops).
// ---------------------------------------------------------------------------
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_MADD  = 3'd6,
      MD_MADDU = 3'd7
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   localparam logic [1:0] MD_SEL_LO = 2'd0;
   localparam logic [1:0] MD_SEL_HI = 2'd1;

   localparam int MD_CNT_W = 8;

   function automatic logic md_is_arith(input md_op_e op);
      logic arith;
      arith = 1'b0;
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: arith = 1'b1;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MADDU:                  arith = 1'b1;
`endif
         default:                            arith = 1'b0;
      endcase
      return arith;
   endfunction

endpackage

// File: rtl/e_md_calc.sv
// ---------------------------------------------------------------------------
// e_md_calc
//   Combinational 2*WIDTH result generator. Output is {HI, LO} for the
//   latched operation; the top only samples it on the commit edge.
//   Ports:
//     op_i      latched operation
//     rs_i      latched operand A (dividend)
//     rt_i      latched operand B (divisor)
//     hi_i/lo_i current HI/LO, accumulator base (only with MDU_MADD_EN)
//     result_o  {HI, LO} to commit
//   Optional feature macro: MDU_MADD_EN.
// ---------------------------------------------------------------------------
module e_md_calc
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_e             op_i,
   input  logic [WIDTH-1:0]   rs_i,
   input  logic [WIDTH-1:0]   rt_i,
`ifdef MDU_MADD_EN
   input  logic [WIDTH-1:0]   hi_i,
   input  logic [WIDTH-1:0]   lo_i,
`endif
   output logic [2*WIDTH-1:0] result_o
);

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic               div_zero;
   logic               div_ovf;

   // Full-width products of sign/zero extended operands; the low 2*WIDTH
   // bits are the exact signed/unsigned product.
   assign prod_s = {{WIDTH{rs_i[WIDTH-1]}}, rs_i} * {{WIDTH{rt_i[WIDTH-1]}}, rt_i};
   assign prod_u = {{WIDTH{1'b0}}, rs_i} * {{WIDTH{1'b0}}, rt_i};

   assign div_zero = (rt_i == '0);
   assign div_ovf  = (rs_i == {1'b1, {(WIDTH-1){1'b0}}}) && (rt_i == {WIDTH{1'b1}});

   always_comb begin
      quo      = '0;
      rem      = '0;
      result_o = '0;
      case (op_i)
         MD_MULT:  result_o = prod_s;
         MD_MULTU: result_o = prod_u;
         MD_DIV: begin
            if (div_zero) begin
               result_o = {rs_i, {WIDTH{1'b1}}};
            end else if (div_ovf) begin
               result_o = {{WIDTH{1'b0}}, rs_i};
            end else begin
               // SV signed / and % truncate toward zero, remainder takes
               // the dividend's sign.
               quo      = $signed(rs_i) / $signed(rt_i);
               rem      = $signed(rs_i) % $signed(rt_i);
               result_o = {rem, quo};
            end
         end
         MD_DIVU: begin
            if (div_zero) begin
               result_o = {rs_i, {WIDTH{1'b1}}};
            end else begin
               quo      = rs_i / rt_i;
               rem      = rs_i % rt_i;
               result_o = {rem, quo};
            end
         end
`ifdef MDU_MADD_EN
         MD_MADD:  result_o = {hi_i, lo_i} + prod_s;
         MD_MADDU: result_o = {hi_i, lo_i} + prod_u;
`endif
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/e_md_unit.sv
// ---------------------------------------------------------------------------
// e_md_unit
//   E-stage multiply/divide unit. Latches operands on an accepted start,
//   holds E_MDBusy for a fixed latency, then commits {HI, LO}. MTHI/MTLO
//   write directly without a busy window. Also provides the HI/LO read mux.
//   Ports:
//     clk         clock, rising edge
//     reset       synchronous, active-low
//     E_MDStart   issue E_MDOp this cycle
//     E_MDCancel  exception/interrupt, suppresses E_MDStart
//     E_MDOp      operation (md_op_e encoding)
//     E_RS/E_RT   operands A/B
//     E_MDDataOp  read select: LO, HI, otherwise zero
//     E_MDData    selected HI/LO
//     E_MDBusy    operation in flight
//   Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate).
//   Latencies must be 1..255 (MD_CNT_W counter).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   MD_IDLE | ready; accepts starts, MTHI/MTLO write HI/LO immediately
//   MD_RUN  | op in flight; counter LAT..1, commit {HI,LO} when counter==1
// ---------------------------------------------------------------------------
module e_md_unit
   import md_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             E_MDStart,
   input  logic             E_MDCancel,
   input  logic [2:0]       E_MDOp,
   input  logic [WIDTH-1:0] E_RS,
   input  logic [WIDTH-1:0] E_RT,
   input  logic [1:0]       E_MDDataOp,
   output logic [WIDTH-1:0] E_MDData,
   output logic             E_MDBusy
);

   localparam logic [MD_CNT_W-1:0] MULT_CNT = MD_CNT_W'(MULT_LAT);
   localparam logic [MD_CNT_W-1:0] DIV_CNT  = MD_CNT_W'(DIV_LAT);
   localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

   md_state_e           state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   md_op_e              op_q, op_d;
   logic [WIDTH-1:0]    rs_q, rs_d;
   logic [WIDTH-1:0]    rt_q, rt_d;
   logic [WIDTH-1:0]    hi_q, hi_d;
   logic [WIDTH-1:0]    lo_q, lo_d;

   md_op_e              op_in;
   logic                accept;
   logic [2*WIDTH-1:0]  calc_res;

   assign op_in    = md_op_e'(E_MDOp);
   assign accept   = E_MDStart & ~E_MDCancel & (state_q == MD_IDLE);
   assign E_MDBusy = (state_q == MD_RUN);

   e_md_calc #(
      .WIDTH    (WIDTH)
   ) u_calc (
      .op_i     (op_q),
      .rs_i     (rs_q),
      .rt_i     (rt_q),
`ifdef MDU_MADD_EN
      .hi_i     (hi_q),
      .lo_i     (lo_q),
`endif
      .result_o (calc_res)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (accept) begin
               if (md_is_arith(op_in)) begin
                  state_d = MD_RUN;
                  cnt_d   = ((op_in == MD_DIV) || (op_in == MD_DIVU)) ? DIV_CNT : MULT_CNT;
                  op_d    = op_in;
                  rs_d    = E_RS;
                  rt_d    = E_RT;
               end else if (op_in == MD_MTHI) begin
                  hi_d = E_RS;
               end else if (op_in == MD_MTLO) begin
                  lo_d = E_RS;
               end
            end
         end
         MD_RUN: begin
            if (cnt_q == CNT_ONE) begin
               state_d      = MD_IDLE;
               cnt_d        = '0;
               {hi_d, lo_d} = calc_res;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_MULT;
         rs_q    <= '0;
         rt_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      case (E_MDDataOp)
         MD_SEL_LO: E_MDData = lo_q;
         MD_SEL_HI: E_MDData = hi_q;
         default:   E_MDData = '0;
      endcase
   end

`ifndef SYNTHESIS
   // The hazard unit should never let a start through while busy; the unit
   // drops it, but flag it so a broken stall path is visible in simulation.
   start_while_busy_a: assert property (@(posedge clk) disable iff (!reset)
      !(E_MDStart && !E_MDCancel && E_MDBusy))
      else $warning("e_md_unit: start while busy dropped");
`endif

endmodule

// File: tb/tb_e_md_unit.sv
module tb_e_md_unit;

   localparam int W  = 32;
   localparam int ML = 5;
   localparam int DL = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          E_MDStart;
   logic          E_MDCancel;
   logic [2:0]    E_MDOp;
   logic [W-1:0]  E_RS;
   logic [W-1:0]  E_RT;
   logic [1:0]    E_MDDataOp;
   logic [W-1:0]  E_MDData;
   logic          E_MDBusy;

   int            cmp_cnt = 0;
   int            err_cnt = 0;
   logic [31:0]   m_hi = '0;
   logic [31:0]   m_lo = '0;

`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   e_md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk        (clk),
      .reset      (reset),
      .E_MDStart  (E_MDStart),
      .E_MDCancel (E_MDCancel),
      .E_MDOp     (E_MDOp),
      .E_RS       (E_RS),
      .E_RT       (E_RT),
      .E_MDDataOp (E_MDDataOp),
      .E_MDData   (E_MDData),
      .E_MDBusy   (E_MDBusy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d", cmp_cnt);
      $fatal(1, "watchdog");
   end

   // Reference: MIPS HI/LO semantics in plain integer arithmetic.
   function automatic logic [63:0] ref_calc(input int op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
      int          sa;
      int          sb;
      longint      sp;
      logic [63:0] up;
      sa = a;
      sb = b;
      sp = longint'(sa) * longint'(sb);
      up = {32'b0, a} * {32'b0, b};
      case (op)
         0: return sp;
         1: return up;
         2: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            else return {32'(sa % sb), 32'(sa / sb)};
         end
         3: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            else return {a % b, a / b};
         end
         6: return {hi, lo} + sp;
         7: return {hi, lo} + up;
         default: return {hi, lo};
      endcase
   endfunction

   function automatic bit is_arith(input int op);
      return (op <= 3) || (MADD_EN && op >= 6);
   endfunction

   function automatic int lat_of(input int op);
      return (op == 2 || op == 3) ? DL : ML;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      E_MDDataOp = 2'd1;
      #1;
      hi = E_MDData;
      E_MDDataOp = 2'd0;
      #1;
      lo = E_MDData;
   endtask

   // Issue one op, watch the busy window, check reads during busy and the
   // final HI/LO. inject>0 drives a stray MULT start in that busy cycle.
   task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input bit cancel, input int inject, input string tag);
      logic [63:0] exp;
      logic [31:0] hi;
      logic [31:0] lo;
      int          exp_lat;
      int          n;
      exp_lat = (!cancel && is_arith(op)) ? lat_of(op) : 0;
      if (cancel)                exp = {m_hi, m_lo};
      else if (op == 4)          exp = {a, m_lo};
      else if (op == 5)          exp = {m_hi, a};
      else if (is_arith(op))     exp = ref_calc(op, a, b, m_hi, m_lo);
      else                       exp = {m_hi, m_lo};
      E_MDStart  = 1'b1;
      E_MDCancel = cancel;
      E_MDOp     = op[2:0];
      E_RS       = a;
      E_RT       = b;
      tick();
      E_MDStart  = 1'b0;
      E_MDCancel = 1'b0;
      E_RS       = $urandom;
      E_RT       = $urandom;
      n = 0;
      while (E_MDBusy === 1'b1 && n < 200) begin
         n++;
         read_hilo(hi, lo);
         cmp_cnt++;
         if ({hi, lo} !== {m_hi, m_lo}) begin
            err_cnt++;
            $display("FAIL %s busy_read cyc%0d: got %h_%h want %h_%h", tag, n, hi, lo, m_hi, m_lo);
         end
         if (n == inject) begin
            E_MDStart = 1'b1;
            E_MDOp    = 3'd0;
            E_RS      = $urandom;
            E_RT      = $urandom;
         end
         tick();
         E_MDStart = 1'b0;
      end
      cmp_cnt++;
      if (n != exp_lat) begin
         err_cnt++;
         $display("FAIL %s busy_len: got %0d want %0d", tag, n, exp_lat);
      end
      read_hilo(hi, lo);
      cmp_cnt++;
      if ({hi, lo} !== exp) begin
         err_cnt++;
         $display("FAIL %s result: got %h_%h want %h", tag, hi, lo, exp);
      end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      if (inject > 0) begin
         tick();
         cmp_cnt++;
         if (E_MDBusy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s stray_start_busy: got %b want 0", tag, E_MDBusy);
         end
      end
   endtask

   task automatic check_hilo_const(input logic [31:0] want_hi, input logic [31:0] want_lo, input string tag);
      logic [31:0] hi;
      logic [31:0] lo;
      read_hilo(hi, lo);
      cmp_cnt++;
      if (hi !== want_hi || lo !== want_lo) begin
         err_cnt++;
         $display("FAIL %s const: got %h_%h want %h_%h", tag, hi, lo, want_hi, want_lo);
      end
   endtask

   task automatic test_reset();
      logic [31:0] hi;
      logic [31:0] lo;
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      cmp_cnt++;
      if (E_MDBusy !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_busy: got %b want 0", E_MDBusy);
      end
      read_hilo(hi, lo);
      cmp_cnt++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
         err_cnt++;
         $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo);
      end
      m_hi = '0;
      m_lo = '0;
   endtask

   task automatic test_mult_div();
      do_op(0, 32'hFFFFFFFE, 32'd3, 1'b0, 0, "mult_neg");
      check_hilo_const(32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");
      do_op(3, 32'd7, 32'd0, 1'b0, 0, "divu_zero");
      check_hilo_const(32'd7, 32'hFFFFFFFF, "divu_zero");
      do_op(2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, "div_ovf");
      check_hilo_const(32'h0, 32'h80000000, "div_ovf");
   endtask

   task automatic test_start_while_busy();
      do_op(2, 32'hFFFFFFF9, 32'd2, 1'b0, 3, "div_neg");
      check_hilo_const(32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
   endtask

   task automatic test_mt_cancel();
      do_op(4, 32'h1234, 32'd0, 1'b1, 0, "mthi_cancel");
      check_hilo_const(32'hFFFFFFFF, 32'hFFFFFFFD, "mthi_cancel");
      do_op(5, 32'h55, 32'd0, 1'b0, 0, "mtlo");
      check_hilo_const(32'hFFFFFFFF, 32'h55, "mtlo");
   endtask

   task automatic test_reset_midop();
      logic [31:0] hi;
      logic [31:0] lo;
      do_op(4, 32'hAAAA, 32'd0, 1'b0, 0, "pre_mthi");
      do_op(5, 32'h5555, 32'd0, 1'b0, 0, "pre_mtlo");
      E_MDStart = 1'b1;
      E_MDOp    = 3'd1;
      E_RS      = 32'h10000;
      E_RT      = 32'h10000;
      tick();
      E_MDStart = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      cmp_cnt++;
      if (E_MDBusy !== 1'b0) begin
         err_cnt++;
         $display("FAIL midop_reset_busy: got %b want 0", E_MDBusy);
      end
      read_hilo(hi, lo);
      cmp_cnt++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
         err_cnt++;
         $display("FAIL midop_reset_hilo: got %h_%h want 0_0", hi, lo);
      end
      repeat (ML + 2) tick();
      read_hilo(hi, lo);
      cmp_cnt++;
      if (E_MDBusy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         err_cnt++;
         $display("FAIL midop_discard: got busy=%b %h_%h want busy=0 0_0", E_MDBusy, hi, lo);
      end
      m_hi = '0;
      m_lo = '0;
   endtask

   task automatic test_madd();
      do_op(4, 32'h0, 32'd0, 1'b0, 0, "madd_mthi");
      do_op(5, 32'hFFFFFFFF, 32'd0, 1'b0, 0, "madd_mtlo");
      do_op(7, 32'd1, 32'd1, 1'b0, 0, "maddu");
      if (MADD_EN) check_hilo_const(32'h1, 32'h0, "maddu");
      else         check_hilo_const(32'h0, 32'hFFFFFFFF, "maddu_off");
      do_op(6, 32'hFFFFFFFF, 32'd5, 1'b0, 0, "madd");
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         int          op;
         bit          cancel;
         logic [31:0] a;
         logic [31:0] b;
         op     = $urandom_range(0, 7);
         cancel = ($urandom_range(0, 7) == 0);
         a      = pick_operand();
         b      = pick_operand();
         do_op(op, a, b, cancel, 0, "random");
      end
   endtask

   task automatic test_datasel();
      do_op(4, 32'hDEADBEEF, 32'd0, 1'b0, 0, "sel_mthi");
      do_op(5, 32'hCAFEF00D, 32'd0, 1'b0, 0, "sel_mtlo");
      for (int s = 2; s < 4; s++) begin
         E_MDDataOp = s[1:0];
         #1;
         cmp_cnt++;
         if (E_MDData !== 32'h0) begin
            err_cnt++;
            $display("FAIL datasel_%0d: got %h want 0", s, E_MDData);
         end
      end
      E_MDDataOp = 2'd0;
   endtask

   initial begin
      reset      = 1'b0;
      E_MDStart  = 1'b0;
      E_MDCancel = 1'b0;
      E_MDOp     = 3'd0;
      E_RS       = '0;
      E_RT       = '0;
      E_MDDataOp = 2'd0;
      test_reset();
      test_mult_div();
      test_start_while_busy();
      test_mt_cancel();
      test_reset_midop();
      test_madd();
      test_random();
      test_datasel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
